demux7: RTL and testbench
=========================

Name: demux7

Overview:
- Registered 1-to-7 demultiplexer for a 13-bit data word.
- The 3-bit select steers the input word to exactly one of seven output buses; all other buses drive zero.
- Used as the distribution stage that fans a single data path out to seven consumers.
- One clock cycle of latency. Provides a per-output valid vector and an illegal-select flag.

Parameters:
- WIDTH, 13, data width of `in` and of each output bus.
- NOUT, 7, number of output buses. Fixed at 7 for this block; `sel` code 7 is illegal.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sel  input  3  output select, 0..6 valid; 7 illegal.
- in  input  WIDTH  data word to route.
- out0  output  WIDTH  bus 0, carries `in` when `sel`==0 (registered).
- out1  output  WIDTH  bus 1, `sel`==1.
- out2  output  WIDTH  bus 2, `sel`==2.
- out3  output  WIDTH  bus 3, `sel`==3.
- out4  output  WIDTH  bus 4, `sel`==4.
- out5  output  WIDTH  bus 5, `sel`==5.
- out6  output  WIDTH  bus 6, `sel`==6.
- out_valid  output  NOUT  one-hot; bit k=1 means outk holds routed data this cycle.
- sel_err  output  1  1 when the last sampled `sel` was 7.

Behaviour:
- Clocking: one clock, one register stage.
  - `sel` and `in` are sampled on each rising edge of `clk`.
  - Outputs reflect that sample until the next edge.
- Reset:
  - `rst_n` low asynchronously forces out0..out6 = 0, `out_valid` = 0 and `sel_err` = 0, regardless of `clk`.
  - Outputs hold these values while `rst_n` is low.
  - After `rst_n` deasserts, the first rising edge samples normally.
  - Reset asserted mid-operation clears outputs immediately; no data is retained.
- Routing, `sel` = k in 0..6, at each edge:
  - outk <= `in`.
  - Every outj for j≠k <= 0.
  - `out_valid` <= one-hot with only bit k set.
  - `sel_err` <= 0.
- Illegal select, `sel` = 7:
  - All out0..out6 <= 0.
  - `out_valid` <= 0.
  - `sel_err` <= 1.
  - Input data is dropped.
- Zero data: `in` = 0 with a legal `sel` still sets the corresponding `out_valid` bit. Valid is independent of data value.
- Consecutive cycles with different `sel`: the previously selected bus returns to 0 on the same edge that the new bus loads. There is no overlap and no gap cycle.
- Same `sel` over consecutive cycles: the bus follows `in` each cycle, 1-cycle delayed.
- Latency: exactly 1 cycle from `in`/`sel` to outputs. No combinational path from inputs to outputs.
- No handshake, no backpressure: every cycle is accepted.
- No X propagation on unselected buses: they are hard zero.
- Width: outputs are exactly WIDTH bits. No truncation or extension of `in`.

Test Plan:
- Reset: hold `rst_n`=0 with `sel`=3, `in`=13'h1555, and toggle `clk` -> all outk=0, `out_valid`=0, `sel_err`=0. Then assert `rst_n`=0 asynchronously mid-cycle after routing -> outputs clear without a clock edge.
- Sweep: `in`=13'h1555 with `sel` stepped 0..6, one per cycle -> one cycle later, outk=13'h1555 only for k=`sel`; all other buses 0; `out_valid`=7'b1<<k; `sel_err`=0.
- Return to zero: `sel`=0, `in`=13'h0000 after the sweep -> out0=0, `out_valid`=7'b0000001, all other buses 0.
- Illegal select: `sel`=7, `in`=13'h1FFF -> all buses 0, `out_valid`=0, `sel_err`=1. Next cycle `sel`=2, `in`=13'h0AAA -> out2=13'h0AAA, `sel_err`=0.
- Back-to-back: `sel`=4 with `in`=13'h0001, then 13'h1000 on successive cycles -> out4 shows 13'h0001 then 13'h1000 on successive edges; other buses stay 0.
- Random: 1000 cycles of random `sel`/`in`, checked against a reference model with 1-cycle delay and one-hot `out_valid` -> zero mismatches.

Source files
------------

// File: rtl/demux7.sv
// -----------------------------------------------------------------------------
// demux7 -- registered 1-to-7 demultiplexer.
//
// Fans a single WIDTH-bit data word out to seven consumer buses. On every
// rising clock edge the word on `in` is loaded into the bus chosen by `sel`.
// All other buses load zero. A one-hot valid vector marks the loaded bus.
// A select code of 7 does not address any bus: the word is dropped and
// `sel_err` is raised for that cycle. Latency is exactly one clock, and no
// combinational path runs from the inputs to the outputs.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sel        in   [2:0]        output select, 0..6 legal, 7 illegal
//   in         in   [WIDTH-1:0]  data word to route
//   out0..out6 out  [WIDTH-1:0]  registered output buses, zero when unselected
//   out_valid  out  [NOUT-1:0]   one-hot; bit k set when outk holds routed data
//   sel_err    out  1 when the last sampled `sel` was 7
// -----------------------------------------------------------------------------
module demux7 #(
    parameter int WIDTH = 13,
    parameter int NOUT  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [NOUT-1:0]  out_valid,
    output logic             sel_err
);

    // Per-bus next-state and registered state.
    logic [WIDTH-1:0] bus_d [NOUT];
    logic [WIDTH-1:0] bus_q [NOUT];
    logic [NOUT-1:0]  valid_d;
    logic [NOUT-1:0]  valid_q;
    logic             sel_err_d;
    logic             sel_err_q;

    // -------------------------------------------------------------------------
    // Next-state decode.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before any
        // conditional logic, so no path leaves a signal unassigned and no
        // latch is inferred.
        for (int k = 0; k < NOUT; k++) begin
            bus_d[k] = '0;
        end
        valid_d   = '0;
        sel_err_d = 1'b0;

        // Only the addressed bus takes the word; unselected buses stay hard
        // zero rather than holding stale data.
        for (int k = 0; k < NOUT; k++) begin
            if (sel == 3'(k)) begin
                bus_d[k]   = in;
                valid_d[k] = 1'b1;
            end
        end

        // A code that matched no bus is the illegal select: the word is dropped.
        sel_err_d = (valid_d == '0);
    end

    // -------------------------------------------------------------------------
    // Output register stage.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // that every flop samples the pre-edge values of its inputs.
        if (!rst_n) begin
            for (int k = 0; k < NOUT; k++) begin
                bus_q[k] <= '0;
            end
            valid_q   <= '0;
            sel_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < NOUT; k++) begin
                bus_q[k] <= bus_d[k];
            end
            valid_q   <= valid_d;
            sel_err_q <= sel_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs come straight from flops.
    // -------------------------------------------------------------------------
    assign out0      = bus_q[0];
    assign out1      = bus_q[1];
    assign out2      = bus_q[2];
    assign out3      = bus_q[3];
    assign out4      = bus_q[4];
    assign out5      = bus_q[5];
    assign out6      = bus_q[6];
    assign out_valid = valid_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_demux7.sv
// -----------------------------------------------------------------------------
// tb_demux7 -- self-checking bench for demux7.
//
// Directed vectors come from a table of inputs and expected outputs; random
// traffic uses a small reference model. Expected results are pushed to a
// scoreboard queue as stimulus is driven and popped after the next rising
// edge, when the DUT has produced them. Reset behaviour is checked by hand.
// -----------------------------------------------------------------------------
module tb_demux7;

    localparam int WIDTH = 13;
    localparam int NOUT  = 7;

    // Full output snapshot: bus k occupies slice bus[k].
    typedef struct packed {
        logic [NOUT-1:0][WIDTH-1:0] bus;
        logic [NOUT-1:0]            valid;
        logic                       err;
    } snap_t;

    // Directed vector: inputs plus the expected valid/err and the data that
    // should appear on the bus flagged by exp_valid.
    typedef struct {
        logic [2:0]       sel;
        logic [WIDTH-1:0] din;
        logic [NOUT-1:0]  exp_valid;
        logic             exp_err;
        logic [WIDTH-1:0] exp_data;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic [2:0]       sel;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out0, out1, out2, out3, out4, out5, out6;
    logic [NOUT-1:0]  out_valid;
    logic             sel_err;

    int n_cmp;
    int n_err;

    snap_t sb_q [$];
    vec_t  vecs [$];

    demux7 #(.WIDTH(WIDTH), .NOUT(NOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .in        (in),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out_valid (out_valid),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t actual();
        snap_t s;
        s.bus[0] = out0;
        s.bus[1] = out1;
        s.bus[2] = out2;
        s.bus[3] = out3;
        s.bus[4] = out4;
        s.bus[5] = out5;
        s.bus[6] = out6;
        s.valid  = out_valid;
        s.err    = sel_err;
        return s;
    endfunction

    // Independent reference: 1-to-7 routing with code 7 flagged as illegal.
    function automatic snap_t model(input logic [2:0] s, input logic [WIDTH-1:0] d);
        snap_t e;
        e = '0;
        if (s == 3'd7) begin
            e.err = 1'b1;
        end else begin
            for (int k = 0; k < NOUT; k++) begin
                if (int'(s) == k) begin
                    e.bus[k]   = d;
                    e.valid[k] = 1'b1;
                end
            end
        end
        return e;
    endfunction

    function automatic snap_t from_vec(input vec_t v);
        snap_t e;
        e       = '0;
        e.valid = v.exp_valid;
        e.err   = v.exp_err;
        for (int k = 0; k < NOUT; k++) begin
            if (v.exp_valid[k]) e.bus[k] = v.exp_data;
        end
        return e;
    endfunction

    task automatic check(input string name, input snap_t act, input snap_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got bus=%h valid=%b err=%b, expected bus=%h valid=%b err=%b",
                     name, act.bus, act.valid, act.err, exp.bus, exp.valid, exp.err);
        end
    endtask

    // Drive one sample on the falling edge, queue its expectation, then
    // compare once the next rising edge has registered it.
    task automatic step(input string name, input logic [2:0] s,
                        input logic [WIDTH-1:0] d, input snap_t exp);
        snap_t e;
        @(negedge clk);
        sel = s;
        in  = d;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check(name, actual(), e);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        sel   = 3'd3;
        in    = 13'h1555;

        // Directed table.
        for (int k = 0; k < NOUT; k++) begin
            vecs.push_back('{3'(k), 13'h1555, 7'(1 << k), 1'b0, 13'h1555});
        end
        vecs.push_back('{3'd0, 13'h0000, 7'b0000001, 1'b0, 13'h0000});
        vecs.push_back('{3'd7, 13'h1FFF, 7'b0000000, 1'b1, 13'h0000});
        vecs.push_back('{3'd2, 13'h0AAA, 7'b0000100, 1'b0, 13'h0AAA});
        vecs.push_back('{3'd4, 13'h0001, 7'b0010000, 1'b0, 13'h0001});
        vecs.push_back('{3'd4, 13'h1000, 7'b0010000, 1'b0, 13'h1000});
        vecs.push_back('{3'd6, 13'h1FFF, 7'b1000000, 1'b0, 13'h1FFF});
        vecs.push_back('{3'd7, 13'h0123, 7'b0000000, 1'b1, 13'h0000});
        vecs.push_back('{3'd7, 13'h0456, 7'b0000000, 1'b1, 13'h0000});

        // Reset held with a legal select and clock running: outputs stay zero.
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", actual(), '0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d_sel%0d", i, vecs[i].sel),
                 vecs[i].sel, vecs[i].din, from_vec(vecs[i]));
        end

        // Asynchronous reset mid-cycle after routing: clears with no edge.
        step("pre_async_route", 3'd5, 13'h0B0B,
             '{bus: {13'h0, 13'h0B0B, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0},
               valid: 7'b0100000, err: 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", actual(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset release samples normally.
        step("post_reset_first", 3'd1, 13'h1234, model(3'd1, 13'h1234));

        // Random traffic against the reference model.
        for (int i = 0; i < 1000; i++) begin
            logic [2:0]       rs;
            logic [WIDTH-1:0] rd;
            rs = 3'($urandom_range(0, 7));
            rd = WIDTH'($urandom);
            step($sformatf("rand%0d", i), rs, rd, model(rs, rd));
        end

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
